// File: rtl/adder_accumulator.sv
// rtl/adder_accumulator.sv - accumulates COUNT upstream sums per run into one registered total with an overflow flag
// Optional feature macro: ADDER_ACC_SATURATE_EN (saturate instead of wrapping on overflow).
module adder_accumulator #(
    parameter int WIDTH1 = 4,
    parameter int WIDTH2 = 4,
    parameter int COUNT  = 8,
    parameter int ACCW   = 11
) (
    input  logic                     clk,
    input  logic                     aclr_n,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic [WIDTH1+WIDTH2-1:0] sum_in,
    output logic                     busy,
    output logic [ACCW-1:0]          acc_out,
    output logic                     acc_valid,
    output logic                     ovf
);

    localparam int SW = WIDTH1 + WIDTH2;
    localparam int CW = $clog2(COUNT);
    localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ACCW-1:0] acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_r_q, ovf_r_d;
    logic [ACCW-1:0] acc_out_q, acc_out_d;
    logic            ovf_q, ovf_d;

    logic [ACCW:0]   sum_ext;
    logic            carry;
    logic [ACCW-1:0] acc_upd;
    logic            accept;
    logic            last_sample;

    // One extra bit of headroom exposes the carry out of the accumulator.
    always_comb begin
        sum_ext = {1'b0, acc_q} + {{(ACCW + 1 - SW){1'b0}}, sum_in};
        carry   = sum_ext[ACCW];
`ifdef ADDER_ACC_SATURATE_EN
        acc_upd = carry ? {ACCW{1'b1}} : sum_ext[ACCW-1:0];
`else
        acc_upd = sum_ext[ACCW-1:0];
`endif
    end

    assign accept      = (state_q == S_ACCUM) && in_valid;
    assign last_sample = accept && (cnt_q == LAST);

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ACCUM;
            S_ACCUM: if (last_sample) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == S_ACCUM) || (state_q == S_DONE);
        acc_valid = (state_q == S_DONE);
    end

    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_r_d   = ovf_r_q;
        acc_out_d = acc_out_q;
        ovf_d     = ovf_q;
        if (state_q == S_IDLE && start) begin
            acc_d   = '0;
            cnt_d   = '0;
            ovf_r_d = 1'b0;
        end else if (accept) begin
            acc_d   = acc_upd;
            cnt_d   = cnt_q + 1'b1;
            ovf_r_d = ovf_r_q | carry;
            // Publish the post-update values so the final sample is included.
            if (last_sample) begin
                acc_out_d = acc_upd;
                ovf_d     = ovf_r_q | carry;
            end
        end
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_r_q   <= 1'b0;
            acc_out_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_r_q   <= ovf_r_d;
            acc_out_q <= acc_out_d;
            ovf_q     <= ovf_d;
        end
    end

    assign acc_out = acc_out_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_adder_accumulator.sv
// tb/tb_adder_accumulator.sv - directed self-checking bench for adder_accumulator (default and ACCW=8 instances)
module tb_adder_accumulator;

    logic        clk = 1'b0;
    logic        aclr_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  sum_in;

    logic        busy_a, acc_valid_a, ovf_a;
    logic [10:0] acc_out_a;
    logic        busy_b, acc_valid_b, ovf_b;
    logic [7:0]  acc_out_b;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    adder_accumulator dut (
        .clk(clk), .aclr_n(aclr_n), .start(start), .in_valid(in_valid), .sum_in(sum_in),
        .busy(busy_a), .acc_out(acc_out_a), .acc_valid(acc_valid_a), .ovf(ovf_a)
    );

    adder_accumulator #(.ACCW(8)) dut8 (
        .clk(clk), .aclr_n(aclr_n), .start(start), .in_valid(in_valid), .sum_in(sum_in),
        .busy(busy_b), .acc_out(acc_out_b), .acc_valid(acc_valid_b), .ovf(ovf_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs then reflect that edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int pulse_at[$];
    int pulse_val_ok;

    initial begin
        start    = 1'b0;
        in_valid = 1'b0;
        sum_in   = 8'd0;
        aclr_n   = 1'b1;
        #1 aclr_n = 1'b0;
        #2;
        check("reset_busy", busy_a, 0);
        check("reset_acc_out", acc_out_a, 0);
        check("reset_acc_valid", acc_valid_a, 0);
        check("reset_ovf", ovf_a, 0);
        step();
        aclr_n = 1'b1;
        step();

        // Run 1: 1..8 back-to-back.
        start = 1'b1;
        step();
        check("t1_busy_after_start", busy_a, 1);
        start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            sum_in   = 8'(i);
            step();
            if (i == 7) check("t1_no_valid_early", acc_valid_a, 0);
        end
        in_valid = 1'b0;
        check("t1_acc_valid", acc_valid_a, 1);
        check("t1_acc_out", acc_out_a, 36);
        check("t1_ovf", ovf_a, 0);
        check("t1_busy_done", busy_a, 1);
        step();
        check("t1_valid_pulse_end", acc_valid_a, 0);
        check("t1_busy_fall", busy_a, 0);

        // Run 2: toggling in_valid, junk in IDLE, on the start edge and in DONE.
        in_valid = 1'b1;
        sum_in   = 8'd100;
        step();
        step();
        check("t2_idle_ignored", busy_a, 0);
        start  = 1'b1;
        sum_in = 8'd50;
        step();
        start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            sum_in   = 8'(i);
            step();
            if (i < 8) begin
                in_valid = 1'b0;
                sum_in   = 8'd99;
                step();
            end
        end
        check("t2_acc_valid", acc_valid_a, 1);
        check("t2_acc_out", acc_out_a, 36);
        in_valid = 1'b1;
        sum_in   = 8'd77;
        step();
        check("t2_done_drop_valid", acc_valid_a, 0);
        check("t2_acc_out_hold", acc_out_a, 36);
        in_valid = 1'b0;
        step();

        // Run 3: 8 x 255, default width holds 2040, 8-bit width overflows.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            sum_in   = 8'd255;
            step();
        end
        in_valid = 1'b0;
        check("t3_valid_w11", acc_valid_a, 1);
        check("t3_acc_out_w11", acc_out_a, 2040);
        check("t3_ovf_w11", ovf_a, 0);
        check("t3_valid_w8", acc_valid_b, 1);
`ifdef ADDER_ACC_SATURATE_EN
        check("t3_acc_out_w8_sat", acc_out_b, 255);
`else
        check("t3_acc_out_w8_wrap", acc_out_b, 248);
`endif
        check("t3_ovf_w8", ovf_b, 1);
        step();

        // Run 4: reset after 5 samples of 10, then a clean run of 8 x 3.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            sum_in   = 8'd10;
            step();
        end
        in_valid = 1'b0;
        check("t4_busy_midrun", busy_a, 1);
        aclr_n = 1'b0;
        #1;
        check("t4_rst_busy", busy_a, 0);
        check("t4_rst_acc_out", acc_out_a, 0);
        check("t4_rst_acc_valid", acc_valid_a, 0);
        check("t4_rst_ovf_w8", ovf_b, 0);
        check("t4_rst_acc_out_w8", acc_out_b, 0);
        step();
        aclr_n = 1'b1;
        step();
        check("t4_idle_after_rst", busy_a, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            sum_in   = 8'd3;
            step();
        end
        in_valid = 1'b0;
        check("t4_valid", acc_valid_a, 1);
        check("t4_acc_out", acc_out_a, 24);
        step();

        // Run 5: start held high, continuous samples of 2.
        start        = 1'b1;
        in_valid     = 1'b1;
        sum_in       = 8'd2;
        pulse_val_ok = 1;
        for (int c = 0; c < 36; c++) begin
            step();
            if (acc_valid_a) begin
                pulse_at.push_back(c);
                if (acc_out_a !== 11'd16) pulse_val_ok = 0;
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
        check("t5_pulse_count", (pulse_at.size() >= 3) ? 1 : 0, 1);
        check("t5_acc_out_16", pulse_val_ok, 1);
        if (pulse_at.size() >= 3) begin
            check("t5_gap1", pulse_at[1] - pulse_at[0], 10);
            check("t5_gap2", pulse_at[2] - pulse_at[1], 10);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
